control_card: RTL and testbench

SUBLEQ instruction sequencer for the card-based machine.
- Fetches the operand triple A, B, C at PC, PC+1, PC+2.
- Reads mem[A] and mem[B], writes mem[B]-mem[A] back to B, then branches to C when the result is <= 0; otherwise advances PC by 3.
- Owns the memory request handshake and publishes its state on the 14-bit ctrl bus so other cards can follow the instruction phase.

---
 rtl/subleq_pkg.sv | 43 ++++
 rtl/ack_timer.sv | 30 +++
 rtl/control_card.sv | 174 +++++++++++++++++
 tb/tb_control_card.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ control card.
// SUBLEQ_STEP_EN adds the single-step PAUSE state.
package subleq_pkg;

    localparam int WORD_W = 16;
    localparam int CTRL_W = 14;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH_A,
        ST_FETCH_B,
        ST_FETCH_C,
        ST_READ_MA,
        ST_READ_MB,
        ST_WRITE_B,
        ST_BRANCH,
        ST_HALT
`ifdef SUBLEQ_STEP_EN
        , ST_PAUSE
`endif
    } state_t;

    localparam int CTRL_ST_IDLE    = 0;
    localparam int CTRL_ST_FETCH_A = 1;
    localparam int CTRL_ST_FETCH_B = 2;
    localparam int CTRL_ST_FETCH_C = 3;
    localparam int CTRL_ST_READ_MA = 4;
    localparam int CTRL_ST_READ_MB = 5;
    localparam int CTRL_ST_WRITE_B = 6;
    localparam int CTRL_ST_BRANCH  = 7;
    localparam int CTRL_ST_HALT    = 8;
    localparam int CTRL_MEM_RD     = 9;
    localparam int CTRL_MEM_WR     = 10;
    localparam int CTRL_BR         = 11;
    localparam int CTRL_HALT       = 12;
    localparam int CTRL_BUSY       = 13;

    function automatic logic is_mem_state(input state_t s);
        return s inside {ST_FETCH_A, ST_FETCH_B, ST_FETCH_C,
                         ST_READ_MA, ST_READ_MB, ST_WRITE_B};
    endfunction

endpackage

// File: rtl/ack_timer.sv
// Memory-ack watchdog: down-counter reloaded on clear, expires on terminal count.
// TIMEOUT=0 disables expiry.
module ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LOAD = (TIMEOUT > 0) ? 16'(TIMEOUT - 1) : 16'd0;

    logic [15:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != 16'd0)) begin
            cnt <= cnt - 16'd1;
        end
    end

    // Expiry fires on the edge that would complete the TIMEOUT-th unacked cycle.
    assign expired = (TIMEOUT != 0) && enable && (cnt == 16'd0);

endmodule

// File: rtl/control_card.sv
// SUBLEQ instruction sequencer: fetch A/B/C, read mem[A]/mem[B], write back, branch.
// Optional macro SUBLEQ_STEP_EN adds step_mode/step and a PAUSE state after BRANCH.
//
// state    | meaning
// IDLE     | waiting for start after reset
// FETCH_A  | read operand A at pc
// FETCH_B  | read operand B at pc+1
// FETCH_C  | read operand C at pc+2
// READ_MA  | read mem[A]
// READ_MB  | read mem[B]
// WRITE_B  | write mem[B]-mem[A] to B, latch leq
// BRANCH   | update pc or halt (one cycle)
// HALT     | stopped by halt branch or ack timeout
// PAUSE    | single-step hold (SUBLEQ_STEP_EN only)
module control_card
    import subleq_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = 16'h0000,
    parameter logic [WORD_W-1:0] HALT_ADDR   = 16'hFFFF,
    parameter int                ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
`ifdef SUBLEQ_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic [WORD_W-1:0] pc,
    output logic              halted,
    output logic              fault,
    output logic [CTRL_W-1:0] ctrl
);

    state_t            state, state_n;
    logic [WORD_W-1:0] reg_a, reg_b, reg_c, reg_ma, reg_mb;
    logic [WORD_W-1:0] diff;
    logic              leq;
    logic              req;
    logic              timer_clear, timer_en, timer_expired;
    logic              halt_branch;

    assign diff        = reg_mb - reg_ma;
    assign req         = is_mem_state(state);
    assign mem_rd      = req && (state != ST_WRITE_B);
    assign mem_wr      = (state == ST_WRITE_B);
    assign halted      = (state == ST_HALT);
    assign halt_branch = leq && (reg_c == HALT_ADDR);
    assign timer_clear = !req || mem_ack;
    assign timer_en    = req && !mem_ack;

    ack_timer #(.TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_FETCH_A: mem_addr = pc;
            ST_FETCH_B: mem_addr = pc + WORD_W'(1);
            ST_FETCH_C: mem_addr = pc + WORD_W'(2);
            ST_READ_MA: mem_addr = reg_a;
            ST_READ_MB: mem_addr = reg_b;
            ST_WRITE_B: begin
                mem_addr  = reg_b;
                mem_wdata = diff;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_HALT: if (start) state_n = ST_FETCH_A;
            ST_FETCH_A: if (mem_ack) state_n = ST_FETCH_B; else if (timer_expired) state_n = ST_HALT;
            ST_FETCH_B: if (mem_ack) state_n = ST_FETCH_C; else if (timer_expired) state_n = ST_HALT;
            ST_FETCH_C: if (mem_ack) state_n = ST_READ_MA; else if (timer_expired) state_n = ST_HALT;
            ST_READ_MA: if (mem_ack) state_n = ST_READ_MB; else if (timer_expired) state_n = ST_HALT;
            ST_READ_MB: if (mem_ack) state_n = ST_WRITE_B; else if (timer_expired) state_n = ST_HALT;
            ST_WRITE_B: if (mem_ack) state_n = ST_BRANCH;  else if (timer_expired) state_n = ST_HALT;
            ST_BRANCH: begin
                if (halt_branch) begin
                    state_n = ST_HALT;
                end else begin
`ifdef SUBLEQ_STEP_EN
                    state_n = step_mode ? ST_PAUSE : ST_FETCH_A;
`else
                    state_n = ST_FETCH_A;
`endif
                end
            end
`ifdef SUBLEQ_STEP_EN
            ST_PAUSE: if (step || !step_mode) state_n = ST_FETCH_A;
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            reg_a  <= '0;
            reg_b  <= '0;
            reg_c  <= '0;
            reg_ma <= '0;
            reg_mb <= '0;
            leq    <= 1'b0;
            fault  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc    <= RESET_PC;
                        fault <= 1'b0;
                    end
                end
                ST_FETCH_A: if (mem_ack) reg_a  <= mem_rdata;
                ST_FETCH_B: if (mem_ack) reg_b  <= mem_rdata;
                ST_FETCH_C: if (mem_ack) reg_c  <= mem_rdata;
                ST_READ_MA: if (mem_ack) reg_ma <= mem_rdata;
                ST_READ_MB: if (mem_ack) reg_mb <= mem_rdata;
                ST_WRITE_B: if (mem_ack) leq <= diff[WORD_W-1] || (diff == '0);
                ST_BRANCH: begin
                    // A halting branch leaves pc on the halting instruction.
                    if (leq) begin
                        if (!halt_branch) pc <= reg_c;
                    end else begin
                        pc <= pc + WORD_W'(3);
                    end
                end
                default: ;
            endcase
            if (timer_expired) fault <= 1'b1;
        end
    end

    always_comb begin
        ctrl                  = '0;
        ctrl[CTRL_ST_IDLE]    = (state == ST_IDLE);
        ctrl[CTRL_ST_FETCH_A] = (state == ST_FETCH_A);
        ctrl[CTRL_ST_FETCH_B] = (state == ST_FETCH_B);
        ctrl[CTRL_ST_FETCH_C] = (state == ST_FETCH_C);
        ctrl[CTRL_ST_READ_MA] = (state == ST_READ_MA);
        ctrl[CTRL_ST_READ_MB] = (state == ST_READ_MB);
        ctrl[CTRL_ST_WRITE_B] = (state == ST_WRITE_B);
        ctrl[CTRL_ST_BRANCH]  = (state == ST_BRANCH);
`ifdef SUBLEQ_STEP_EN
        // PAUSE shares the HALT one-hot slot but not the halted flag.
        ctrl[CTRL_ST_HALT]    = (state == ST_HALT) || (state == ST_PAUSE);
`else
        ctrl[CTRL_ST_HALT]    = (state == ST_HALT);
`endif
        ctrl[CTRL_MEM_RD]     = mem_rd;
        ctrl[CTRL_MEM_WR]     = mem_wr;
        ctrl[CTRL_BR]         = (state == ST_BRANCH) && leq;
        ctrl[CTRL_HALT]       = halted;
        ctrl[CTRL_BUSY]       = (state != ST_IDLE) && (state != ST_HALT);
    end

endmodule

// File: tb/tb_control_card.sv
// Self-checking bench for control_card: memory responder with programmable ack
// latency plus an instruction-level SUBLEQ reference model.
module tb_control_card;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic        mem_rd, mem_wr, halted, fault;
    logic        mem_ack = 1'b0;
    logic [13:0] ctrl;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    bit ack_en = 1'b1;

    always #5 clk = ~clk;

    control_card #(
        .RESET_PC    (16'h0000),
        .HALT_ADDR   (16'hFFFF),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ack   (mem_ack),
`ifdef SUBLEQ_STEP_EN
        .step_mode (1'b0),
        .step      (1'b0),
`endif
        .pc        (pc),
        .halted    (halted),
        .fault     (fault),
        .ctrl      (ctrl)
    );

    // Memory responder: ack after lat waiting cycles, commit writes on the acked edge.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst && ack_en && (mem_rd || mem_wr)) begin
                if (wcnt >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            @(posedge clk);
            if (!rst && mem_ack && mem_wr) mem[mem_addr] = mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    endtask

    task automatic poke(input logic [15:0] ad, input logic [15:0] d);
        mem[ad]     = d;
        ref_mem[ad] = d;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Executes one instruction in the model and checks the DUT against it.
    task automatic check_instr(inout logic [15:0] mpc, inout bit mhalt);
        logic [15:0] a, b, c, r, p1, p2;
        bit          leq;
        int          n;
        p1  = mpc + 16'd1;
        p2  = mpc + 16'd2;
        a   = ref_mem[mpc];
        b   = ref_mem[p1];
        c   = ref_mem[p2];
        r   = ref_mem[b] - ref_mem[a];
        ref_mem[b] = r;
        leq = r[15] || (r == 16'd0);
        n = 0;
        while (!ctrl[7] && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!ctrl[7]) begin
            errors++;
            $display("FAIL reach_branch: ctrl=%h never showed BRANCH, pc_model=%h", ctrl, mpc);
            mhalt = 1'b1;
            return;
        end
        checks++;
        if (ctrl[11] !== leq) begin
            errors++;
            $display("FAIL branch_pulse: got %b expected %b (pc_model=%h)", ctrl[11], leq, mpc);
        end
        @(negedge clk);
        if (leq && c == 16'hFFFF) mhalt = 1'b1;
        else if (leq)             mpc = c;
        else                      mpc = mpc + 16'd3;
        checks++;
        if (pc !== mpc) begin
            errors++;
            $display("FAIL next_pc: got %h expected %h", pc, mpc);
        end
        checks++;
        if (halted !== mhalt) begin
            errors++;
            $display("FAIL halted: got %b expected %b", halted, mhalt);
        end
        checks++;
        if (mem[b] !== r) begin
            errors++;
            $display("FAIL mem_write: mem[%h] got %h expected %h", b, mem[b], r);
        end
    endtask

    task automatic load_basic(input logic [15:0] c, input logic [15:0] mb);
        clear_mem();
        poke(16'd0, 16'd3);
        poke(16'd1, 16'd4);
        poke(16'd2, c);
        poke(16'd3, 16'd5);
        poke(16'd4, mb);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl !== 14'h0001 || mem_rd !== 1'b0 || mem_wr !== 1'b0 || halted !== 1'b0 ||
            fault !== 1'b0 || pc !== 16'h0000 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: ctrl=%h rd=%b wr=%b halted=%b fault=%b pc=%h addr=%h wdata=%h",
                     ctrl, mem_rd, mem_wr, halted, fault, pc, mem_addr, mem_wdata);
        end
        do_reset();
        checks++;
        if (ctrl !== 14'h0001) begin
            errors++;
            $display("FAIL idle_after_reset: ctrl got %h expected 0001", ctrl);
        end
    endtask

    task automatic test_no_branch();
        logic [15:0] mpc;
        bit          mhalt;
        lat = 0;
        do_reset();
        load_basic(16'd6, 16'd7);
        pulse_start();
        mpc = 16'd0; mhalt = 1'b0;
        check_instr(mpc, mhalt);
        checks++;
        if (mem[4] !== 16'd2 || pc !== 16'd3) begin
            errors++;
            $display("FAIL basic_result: mem[4]=%h pc=%h expected 0002/0003", mem[4], pc);
        end
    endtask

    task automatic test_branch();
        logic [15:0] mpc;
        bit          mhalt;
        logic [15:0] vals [2];
        vals[0] = 16'd5;
        vals[1] = 16'd3;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            load_basic(16'd6, vals[k]);
            pulse_start();
            mpc = 16'd0; mhalt = 1'b0;
            check_instr(mpc, mhalt);
            checks++;
            if (pc !== 16'd6) begin
                errors++;
                $display("FAIL branch_target: pc got %h expected 0006", pc);
            end
        end
    endtask

    task automatic test_halt_restart();
        logic [15:0] mpc;
        bit          mhalt;
        do_reset();
        load_basic(16'hFFFF, 16'd5);
        pulse_start();
        mpc = 16'd0; mhalt = 1'b0;
        check_instr(mpc, mhalt);
        checks++;
        if (halted !== 1'b1 || ctrl[12] !== 1'b1 || ctrl[13] !== 1'b0 || ctrl[8] !== 1'b1 || pc !== 16'd0) begin
            errors++;
            $display("FAIL halt_state: halted=%b ctrl=%h pc=%h expected halted with pc 0000", halted, ctrl, pc);
        end
        repeat (3) @(negedge clk);
        pulse_start();
        checks++;
        if (ctrl[1] !== 1'b1 || mem_addr !== 16'd0 || halted !== 1'b0 || pc !== 16'd0) begin
            errors++;
            $display("FAIL restart: ctrl=%h addr=%h halted=%b pc=%h expected FETCH_A at 0000", ctrl, mem_addr, halted, pc);
        end
        mpc = 16'd0; mhalt = 1'b0;
        check_instr(mpc, mhalt);
    endtask

    task automatic test_latency();
        logic [15:0] exp_addr [6];
        logic [15:0] a0;
        int          n, cyc;
        bit          stable;
        exp_addr[0] = 16'd0; exp_addr[1] = 16'd1; exp_addr[2] = 16'd2;
        exp_addr[3] = 16'd3; exp_addr[4] = 16'd4; exp_addr[5] = 16'd4;
        lat = 5;
        do_reset();
        load_basic(16'd6, 16'd7);
        pulse_start();
        for (int s = 1; s <= 6; s++) begin
            n = 0;
            while (!ctrl[s] && n < 100) begin
                @(negedge clk);
                n++;
            end
            a0 = mem_addr;
            cyc = 0;
            stable = 1'b1;
            while (ctrl[s] && cyc < 100) begin
                if (mem_addr !== a0 || ((s < 6) ? (mem_rd !== 1'b1) : (mem_wr !== 1'b1))) stable = 1'b0;
                cyc++;
                @(negedge clk);
            end
            checks++;
            if (cyc != 6 || !stable || a0 !== exp_addr[s-1]) begin
                errors++;
                $display("FAIL hold_state%0d: cycles=%0d stable=%b addr=%h expected 6 cycles stable at %h",
                         s, cyc, stable, a0, exp_addr[s-1]);
            end
        end
        @(negedge clk);
        checks++;
        if (mem[4] !== 16'd2 || pc !== 16'd3) begin
            errors++;
            $display("FAIL latency_result: mem[4]=%h pc=%h expected 0002/0003", mem[4], pc);
        end
        lat = 0;
    endtask

    task automatic test_wrap();
        logic [15:0] mpc;
        bit          mhalt;
        int          n;
        lat = 0;
        do_reset();
        load_basic(16'hFFFE, 16'd5);
        poke(16'hFFFE, 16'd3);
        poke(16'hFFFF, 16'd4);
        pulse_start();
        mpc = 16'd0; mhalt = 1'b0;
        check_instr(mpc, mhalt);
        n = 0;
        while (!ctrl[3] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ctrl[3] !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL fetch_wrap: ctrl=%h addr=%h expected FETCH_C at 0000", ctrl, mem_addr);
        end
        check_instr(mpc, mhalt);
    endtask

    task automatic test_start_ignored();
        logic [15:0] mpc;
        bit          mhalt;
        int          n;
        lat = 2;
        do_reset();
        load_basic(16'd6, 16'd7);
        pulse_start();
        mpc = 16'd0; mhalt = 1'b0;
        n = 0;
        while (!ctrl[4] && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (ctrl[4] !== 1'b1 || mem_addr !== 16'd3) begin
            errors++;
            $display("FAIL start_ignored: ctrl=%h addr=%h expected READ_MA at 0003", ctrl, mem_addr);
        end
        check_instr(mpc, mhalt);
        lat = 0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        ack_en = 1'b0;
        pulse_start();
        checks++;
        if (mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL timeout_req: mem_rd got %b expected 1", mem_rd);
        end
        n = 0;
        while (!halted && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 8 || fault !== 1'b1 || halted !== 1'b1 || ctrl[12] !== 1'b1) begin
            errors++;
            $display("FAIL timeout: after %0d cycles fault=%b halted=%b expected 8 cycles fault=1 halted=1",
                     n, fault, halted);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (mem_rd !== 1'b0 || fault !== 1'b1) begin
            errors++;
            $display("FAIL timeout_after: mem_rd=%b fault=%b expected 0/1", mem_rd, fault);
        end
        ack_en = 1'b1;
        pulse_start();
        checks++;
        if (fault !== 1'b0 || halted !== 1'b0 || ctrl[1] !== 1'b1) begin
            errors++;
            $display("FAIL fault_clear: fault=%b halted=%b ctrl=%h expected 0/0/FETCH_A", fault, halted, ctrl);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        lat = 3;
        do_reset();
        load_basic(16'd6, 16'd7);
        pulse_start();
        n = 0;
        while (!ctrl[6] && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (mem_wr !== 1'b0 || ctrl !== 14'h0001 || mem_addr !== 16'd0 || mem_wdata !== 16'd0) begin
            errors++;
            $display("FAIL async_reset: mem_wr=%b ctrl=%h addr=%h wdata=%h expected idle with no request",
                     mem_wr, ctrl, mem_addr, mem_wdata);
        end
        checks++;
        if (mem[4] !== 16'd7) begin
            errors++;
            $display("FAIL reset_no_write: mem[4] got %h expected 0007", mem[4]);
        end
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
    endtask

    task automatic test_random();
        logic [15:0] mpc;
        bit          mhalt;
        logic [15:0] v;
        for (int it = 0; it < 20; it++) begin
            do_reset();
            clear_mem();
            for (int k = 0; k < 48; k++) begin
                case ($urandom_range(0, 9))
                    0:       v = 16'hFFFF;
                    1:       v = 16'($urandom);
                    default: v = 16'($urandom_range(0, 47));
                endcase
                poke(16'(k), v);
            end
            lat = $urandom_range(0, 3);
            pulse_start();
            mpc = 16'd0; mhalt = 1'b0;
            for (int k = 0; k < 8 && !mhalt; k++) check_instr(mpc, mhalt);
        end
        lat = 0;
    endtask

    initial begin
        test_reset();
        test_no_branch();
        test_branch();
        test_halt_restart();
        test_latency();
        test_wrap();
        test_start_ignored();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
